memory_bram_dp: RTL and testbench

Parametrised simple-dual-port block RAM for the memory physical tile: one write port and one read port on a single clock, with a hardware clear sequencer that zeroes every word after reset. It also provides a selectable read-during-write policy, a read-valid strobe and an optional output pipeline register. It replaces the fixed 1024x8 logical memory primitive as the leaf instantiated under the memory grid tile, so tile depth and width become build-time choices.

---
 rtl/memory_pkg.sv | 24 ++
 rtl/memory_bram_array.sv | 64 ++++++
 rtl/memory_bram_dp.sv | 146 ++++++++++++++
 tb/tb_memory_bram_dp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg
// Description : Shared types and constants for the memory physical-tile
//               block RAM: controller state encoding, read-during-write
//               policy selectors and default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

    localparam int ADDR_W_DEFAULT  = 10;
    localparam int DATA_W_DEFAULT  = 8;

    // Same-address read-during-write policy selectors
    localparam int RDW_READ_FIRST  = 0;  // read returns the pre-write word
    localparam int RDW_WRITE_FIRST = 1;  // read returns the word being written

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_e;

endpackage : memory_pkg
`default_nettype wire

// File: rtl/memory_bram_array.sv
`default_nettype none
// ============================================================================
// Module      : memory_bram_array
// Description : Inferred DEPTH x DATA_W simple-dual-port storage with one
//               write port and one registered read port. The storage itself
//               has no reset; only the read register can be cleared.
// Ports       : clk        - clock
//               i_rd_clr   - synchronous clear of the read register
//               i_we/i_waddr/i_wdata - write port
//               i_re/i_raddr         - read port request
//               o_rdata    - registered read data (holds when i_re = 0)
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bram_array
    import memory_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic              clk,
    input  logic              i_rd_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_bypass;

    // Read-first falls out of non-blocking semantics: the read samples the
    // array before the same-edge write lands. Write-first needs a bypass.
    generate
        if (RDW_MODE == RDW_WRITE_FIRST) begin : g_write_first
            assign w_bypass = i_we && i_re && (i_waddr == i_raddr);
        end else begin : g_read_first
            assign w_bypass = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rd_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_bypass ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : memory_bram_array
`default_nettype wire

// File: rtl/memory_bram_dp.sv
`default_nettype none
// ============================================================================
// Module      : memory_bram_dp
// Description : Simple-dual-port block RAM leaf for the memory grid tile.
//               After reset a clear sequencer zeroes every word (one per
//               cycle) while memory_busy is high; user traffic is dropped
//               during that time. Read latency is 1 cycle, or 2 cycles when
//               the MEMORY_OUT_REG_EN macro adds an output register stage.
// Ports       : memory_clk / memory_rst_n (sync, active-low)
//               memory_wen, memory_waddr, memory_data_in  - write port
//               memory_ren, memory_raddr                   - read request
//               memory_data_out, memory_data_valid         - read result
//               memory_busy                                - clear running
// Config      : MEMORY_OUT_REG_EN - extra output register on data/valid
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bram_dp
    import memory_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic              memory_clk,
    input  logic              memory_rst_n,
    input  logic [ADDR_W-1:0] memory_waddr,
    input  logic [DATA_W-1:0] memory_data_in,
    input  logic              memory_wen,
    input  logic [ADDR_W-1:0] memory_raddr,
    input  logic              memory_ren,
    output logic [DATA_W-1:0] memory_data_out,
    output logic              memory_data_valid,
    output logic              memory_busy
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [ADDR_W:0]   r_ptr;       // one spare bit so the wrap is explicit
    logic [ADDR_W:0]   w_ptr_nxt;
    logic              w_busy;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_re;
    logic [DATA_W-1:0] w_rdata;
    logic              r_valid;

    always_ff @(posedge memory_clk) begin
        if (!memory_rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Clear writes own the write port while busy; user ops are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy      = 1'b0;
        w_we        = 1'b0;
        w_waddr     = memory_waddr;
        w_wdata     = memory_data_in;
        w_re        = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy    = 1'b1;
                w_we      = 1'b1;
                w_waddr   = r_ptr[ADDR_W-1:0];
                w_wdata   = '0;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == C_LAST_PTR) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_we = memory_wen;
                w_re = memory_ren;
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
        // Nothing may touch the array on a reset edge, whatever state we are in.
        if (!memory_rst_n) begin
            w_we = 1'b0;
            w_re = 1'b0;
        end
    end

    memory_bram_array #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RDW_MODE (RDW_MODE)
    ) u_array (
        .clk      (memory_clk),
        .i_rd_clr (~memory_rst_n),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_re     (w_re),
        .i_raddr  (memory_raddr),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge memory_clk) begin
        if (!memory_rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_re;
        end
    end

`ifdef MEMORY_OUT_REG_EN
    logic [DATA_W-1:0] r_data_q;
    logic              r_valid_q;

    always_ff @(posedge memory_clk) begin
        if (!memory_rst_n) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= r_valid;
            if (r_valid) begin
                r_data_q <= w_rdata;
            end
        end
    end

    assign memory_data_out   = r_data_q;
    assign memory_data_valid = r_valid_q;
`else
    assign memory_data_out   = w_rdata;
    assign memory_data_valid = r_valid;
`endif

    assign memory_busy = w_busy;

endmodule : memory_bram_dp
`default_nettype wire

// File: tb/tb_memory_bram_dp.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bram_dp
// Description : Self-checking bench for memory_bram_dp (ADDR_W = 4). Two
//               instances share stimulus, one read-first and one write-first.
//               A behavioural model predicts busy/valid/data every cycle and
//               directed vectors pin literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bram_dp;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
`ifdef MEMORY_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] din;
    logic              wen;
    logic [ADDR_W-1:0] raddr;
    logic              ren;
    logic [DATA_W-1:0] dout_rf, dout_wf;
    logic              valid_rf, valid_wf;
    logic              busy_rf, busy_wf;

    int checks = 0;
    int errors = 0;

    memory_bram_dp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RDW_MODE(0)) u_dut_rf (
        .memory_clk        (clk),
        .memory_rst_n      (rst_n),
        .memory_waddr      (waddr),
        .memory_data_in    (din),
        .memory_wen        (wen),
        .memory_raddr      (raddr),
        .memory_ren        (ren),
        .memory_data_out   (dout_rf),
        .memory_data_valid (valid_rf),
        .memory_busy       (busy_rf)
    );

    memory_bram_dp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RDW_MODE(1)) u_dut_wf (
        .memory_clk        (clk),
        .memory_rst_n      (rst_n),
        .memory_waddr      (waddr),
        .memory_data_in    (din),
        .memory_wen        (wen),
        .memory_raddr      (raddr),
        .memory_ren        (ren),
        .memory_data_out   (dout_wf),
        .memory_data_valid (valid_wf),
        .memory_busy       (busy_wf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Memory contents, clear countdown, and a LAT-deep delay line of read
    // results; the visible output is whatever last emerged from the line.
    logic [DATA_W-1:0] mem_m [DEPTH];
    int                clear_left = 0;
    logic              pv  [LAT];
    logic [DATA_W-1:0] pd0 [LAT];
    logic [DATA_W-1:0] pd1 [LAT];
    logic              exp_busy  = 1'b1;
    logic              exp_valid = 1'b0;
    logic [DATA_W-1:0] exp_d0 = '0, exp_d1 = '0;
    bit                model_ok = 1'b0;

    always @(posedge clk) begin
        logic              nv;
        logic [DATA_W-1:0] n0, n1;
        if (!rst_n) begin
            clear_left = DEPTH;
            for (int k = 0; k < LAT; k++) begin
                pv[k] = 1'b0; pd0[k] = '0; pd1[k] = '0;
            end
            exp_valid = 1'b0; exp_d0 = '0; exp_d1 = '0;
            model_ok  = 1'b1;
        end else begin
            nv = 1'b0; n0 = '0; n1 = '0;
            if (clear_left > 0) begin
                mem_m[DEPTH - clear_left] = '0;
                clear_left--;
            end else begin
                if (ren) begin
                    nv = 1'b1;
                    n0 = mem_m[raddr];
                    n1 = (wen && waddr == raddr) ? din : mem_m[raddr];
                end
                if (wen) mem_m[waddr] = din;
            end
            for (int k = LAT - 1; k > 0; k--) begin
                pv[k] = pv[k-1]; pd0[k] = pd0[k-1]; pd1[k] = pd1[k-1];
            end
            pv[0] = nv; pd0[0] = n0; pd1[0] = n1;
            exp_valid = pv[LAT-1];
            if (exp_valid) begin
                exp_d0 = pd0[LAT-1];
                exp_d1 = pd1[LAT-1];
            end
        end
        exp_busy = (clear_left != 0);
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("busy_rf",  {31'd0, busy_rf},  {31'd0, exp_busy});
            chk("busy_wf",  {31'd0, busy_wf},  {31'd0, exp_busy});
            chk("valid_rf", {31'd0, valid_rf}, {31'd0, exp_valid});
            chk("valid_wf", {31'd0, valid_wf}, {31'd0, exp_valid});
            chk("data_rf",  {24'd0, dout_rf},  {24'd0, exp_d0});
            chk("data_wf",  {24'd0, dout_wf},  {24'd0, exp_d1});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_word(input int a, input int d);
        wen = 1'b1; waddr = 4'(a); din = 8'(d);
        tick();
        wen = 1'b0;
    endtask

    task automatic read_lit(input string name, input int a, input int e_rf, input int e_wf);
        ren = 1'b1; raddr = 4'(a);
        tick();
        ren = 1'b0;
        repeat (LAT - 1) tick();
        chk({name, "_valid"}, {31'd0, valid_rf}, 32'd1);
        chk({name, "_rf"}, {24'd0, dout_rf}, 32'(e_rf));
        chk({name, "_wf"}, {24'd0, dout_wf}, 32'(e_wf));
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy_rf && cnt < 100) begin
            cnt++;
            // User traffic during clear must be dropped.
            if (cnt == 4) begin
                wen = 1'b1; ren = 1'b1; waddr = 4'd2; raddr = 4'd2; din = 8'hFF;
            end
            if (cnt == 6) begin
                wen = 1'b0; ren = 1'b0;
            end
            tick();
        end
        wen = 1'b0; ren = 1'b0;
        chk(name, cnt, 32'd16);
    endtask

    initial begin
        int nvalid;
        int k;
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0;
        waddr = '0; raddr = '0; din = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_busy",  {31'd0, busy_rf},  32'd1);
        chk("rst_valid", {31'd0, valid_rf}, 32'd0);
        chk("rst_data",  {24'd0, dout_rf},  32'd0);
        rst_n = 1'b1;
        count_busy("clear_len");

        // Every word is zero after clear, including addr 2 hit during busy.
        for (int i = 0; i < DEPTH; i++) read_lit("clr_read", i, 0, 0);

        write_word(3, 8'hA5);
        read_lit("wr_rd", 3, 8'hA5, 8'hA5);

        // Same-address collision
        write_word(7, 8'h11);
        wen = 1'b1; waddr = 4'd7; din = 8'h22; ren = 1'b1; raddr = 4'd7;
        tick();
        wen = 1'b0; ren = 1'b0;
        repeat (LAT - 1) tick();
        chk("coll_rf", {24'd0, dout_rf}, 32'h11);
        chk("coll_wf", {24'd0, dout_wf}, 32'h22);
        read_lit("coll_after", 7, 8'h22, 8'h22);

        // Fill with addr ^ 0x5A, then back-to-back reads
        for (int i = 0; i < DEPTH; i++) write_word(i, i ^ 8'h5A);
        nvalid = 0;
        for (int i = 0; i < DEPTH + LAT; i++) begin
            ren = (i < DEPTH); raddr = 4'(i);
            tick();
            if (valid_rf) nvalid++;
            k = i - LAT + 1;
            if (k >= 0 && k < DEPTH) begin
                chk("b2b_valid", {31'd0, valid_rf}, 32'd1);
                chk("b2b_data",  {24'd0, dout_rf},  32'(k ^ 8'h5A));
            end
        end
        ren = 1'b0;
        chk("b2b_count", nvalid, 32'd16);

        // Reset at clear pointer 9, held one cycle
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        repeat (9) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        count_busy("reclear_len");

        // Reset with a read in flight
        write_word(3, 8'h59);
        read_lit("pre_rst", 3, 8'h59, 8'h59);
        ren = 1'b1; raddr = 4'd3;
`ifdef MEMORY_OUT_REG_EN
        tick();
        ren = 1'b0;
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ren = 1'b0;
        chk("inflight_valid", {31'd0, valid_rf}, 32'd0);
        chk("inflight_data",  {24'd0, dout_rf},  32'd0);
        chk("inflight_busy",  {31'd0, busy_rf},  32'd1);
        count_busy("final_clear");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_memory_bram_dp
`default_nettype wire
